duck_sprite_fetch: RTL and testbench
====================================

Name: duck_sprite_fetch

Overview:
- Upstream stage of the duck palette lookup: per VGA pixel, decides whether the current DrawX/DrawY falls inside the duck sprite.
- Generates the sprite ROM address for the current animation frame, and delivers a registered 4-bit palette index plus a pixel-valid flag to the palette block.
- Owns the duck animation frame sequencing and the per-frame latching of position/orientation so the sprite never tears mid-frame.

Parameters:
- SPRITE_W, 46, sprite width in pixels
- SPRITE_H, 40, sprite height in pixels
- NUM_FRAMES, 3, animation frames stored back-to-back in ROM
- FRAME_HOLD, 8, VGA frames each animation frame is shown
- ADDR_W, 13, ROM address width; must satisfy 2^ADDR_W >= NUM_FRAMES*SPRITE_W*SPRITE_H

Ports:
- Clk  in  1  pixel clock
- Reset  in  1  asynchronous, active-high reset
- DrawX  in  10  current pixel column, 0..639
- DrawY  in  10  current pixel row, 0..479
- frame_tick  in  1  one-cycle pulse, once per VGA frame during vertical blank
- duck_x  in  10  requested sprite left edge
- duck_y  in  10  requested sprite top edge
- duck_en  in  1  requested sprite visibility
- flip_h  in  1  requested horizontal mirror (duck facing left)
- anim_pause  in  1  hold the current animation frame
- rom_addr  out  ADDR_W  address to the synchronous sprite ROM
- rom_data  in  4  ROM palette index, valid one cycle after rom_addr
- pal_index  out  4  palette index to the palette block
- pix_valid  out  1  sprite covers this pixel and the index is non-transparent
- anim_frame  out  2  current animation frame, 0..NUM_FRAMES-1

Behaviour:
- Reset: all registers clear asynchronously.
  - rom_addr=0, pal_index=0, pix_valid=0, anim_frame=0, hold counter=0.
  - Shadow registers cleared: x=0, y=0, en=0, flip=0.
- Shadow latch:
  - On a frame_tick cycle, duck_x/duck_y/duck_en/flip_h are captured into shadow registers.
  - At all other times the live inputs are ignored; all hit and address computation uses the shadow values only.
- Animation:
  - On frame_tick with anim_pause=0, the hold counter increments.
  - When the counter equals FRAME_HOLD-1, it clears and anim_frame advances, wrapping NUM_FRAMES-1 -> 0.
  - anim_pause=1 freezes both the counter and anim_frame.
  - Animation updates on the same edge as the shadow latch.
- Stage 1 (registered at edge N+1 for the pixel presented at cycle N):
  - dx = DrawX - sx and dy = DrawY - sy, as 11-bit unsigned subtractions.
  - hit = sen && dx < SPRITE_W && dy < SPRITE_H. The wrap-around of the subtraction rejects pixels left of or above the sprite.
  - col = sflip ? SPRITE_W-1-dx : dx.
  - rom_addr = anim_frame*SPRITE_W*SPRITE_H + dy*SPRITE_W + col, registered; it holds 0 when hit=0.
  - hit is carried through a 2-deep delay alongside the address.
- Stage 2 (edge N+2): rom_data is valid from the ROM; no logic in this block.
- Stage 3 (edge N+3):
  - pal_index = hit_d2 ? rom_data : 0.
  - pix_valid = hit_d2 && (rom_data != 0). Index 0 is the transparent background colour.
- Total latency DrawX/DrawY -> pal_index/pix_valid is 3 cycles, fixed. Downstream aligns DrawX/DrawY by 3.
- The sprite partially beyond the right or bottom screen edge is clipped naturally; negative positions are not supported.
- frame_tick during active video is still honoured. The sprite may then tear for one frame; this is the source's responsibility.
- A Reset assertion mid-frame flushes the pipeline: pix_valid=0 from the reset instant until 3 cycles after hit becomes true again.

Test Plan:
- Reset, then sweep a full frame with no frame_tick -> pix_valid=0 everywhere, rom_addr=0, anim_frame=0.
- duck_x=100, duck_y=50, duck_en=1, one frame_tick, then scan DrawX=100 DrawY=50 -> rom_addr=0 at +1 cycle; ROM returning 3 gives pal_index=3, pix_valid=1 at +3 cycles. DrawX=145,DrawY=89 -> rom_addr=1839. DrawX=146 and DrawX=99 -> pix_valid=0.
- flip_h=1 latched, DrawX=100,DrawY=50 -> rom_addr=45. ROM returning 0 at any hit pixel -> pal_index=0, pix_valid=0.
- 8 frame_ticks -> anim_frame=1; at DrawX=100,DrawY=50 rom_addr=1840. 24 ticks total -> anim_frame wraps to 0. anim_pause=1 across 10 ticks -> anim_frame unchanged.
- Change duck_x to 200 with no frame_tick -> hits remain at x=100. After a frame_tick -> hits at x=200. duck_x=620 -> columns 620..639 hit, no wrap to column 0.
- Assert Reset while pix_valid=1 -> pix_valid, pal_index, anim_frame and the shadow registers go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/duck_sprite_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : duck_sprite_fetch_if
//  Brief    : Pixel/ROM/palette signal bundle for the duck sprite fetch stage.
//             The master side is the VGA timing + sprite ROM environment; the
//             slave side is the fetch block itself.
//  Revision : 1.0  initial release
// ============================================================================
interface duck_sprite_fetch_if #(
    parameter int ADDR_W = 13
);
    // Raster position of the pixel being presented this cycle
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    // Once-per-frame strobe during vertical blank
    logic              frame_tick;
    // Requested sprite state, only sampled on frame_tick
    logic [9:0]        duck_x;
    logic [9:0]        duck_y;
    logic              duck_en;
    logic              flip_h;
    logic              anim_pause;
    // Synchronous sprite ROM: data valid one cycle after address
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;
    // Toward the palette block
    logic [3:0]        pal_index;
    logic              pix_valid;
    logic [1:0]        anim_frame;

    modport master (
        output DrawX, DrawY, frame_tick,
        output duck_x, duck_y, duck_en, flip_h, anim_pause,
        output rom_data,
        input  rom_addr, pal_index, pix_valid, anim_frame
    );

    modport slave (
        input  DrawX, DrawY, frame_tick,
        input  duck_x, duck_y, duck_en, flip_h, anim_pause,
        input  rom_data,
        output rom_addr, pal_index, pix_valid, anim_frame
    );
endinterface
`default_nettype wire

// File: rtl/duck_sprite_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : duck_sprite_fetch
//  Brief    : Per-pixel duck sprite hit test, animated ROM address generation
//             and 3-cycle registered palette-index delivery. Sprite position,
//             visibility and facing are latched once per frame so the sprite
//             never tears within a frame.
//  Revision : 1.0  initial release
// ============================================================================
module duck_sprite_fetch #(
    parameter int SPRITE_W   = 46,
    parameter int SPRITE_H   = 40,
    parameter int NUM_FRAMES = 3,
    parameter int FRAME_HOLD = 8,
    parameter int ADDR_W     = 13
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    duck_sprite_fetch_if.slave bus
);

    // Words per animation frame; frames sit back-to-back in the ROM.
    localparam logic [ADDR_W-1:0] c_FRAME_SIZE = ADDR_W'(SPRITE_W * SPRITE_H);
    localparam logic [ADDR_W-1:0] c_SPRITE_W   = ADDR_W'(SPRITE_W);
    localparam logic [ADDR_W-1:0] c_LAST_COL   = ADDR_W'(SPRITE_W - 1);
    // Hold counter needs at least one bit even when FRAME_HOLD is 1.
    localparam int                c_HOLD_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(FRAME_HOLD - 1);
    localparam logic [1:0]        c_FRAME_LAST = 2'(NUM_FRAMES - 1);

    // ------------------------------------------------------------------
    // Per-frame shadow copy of the requested sprite state
    // ------------------------------------------------------------------
    logic [9:0]          r_sx;
    logic [9:0]          r_sy;
    logic                r_sen;
    logic                r_sflip;

    // Animation sequencing
    logic [c_HOLD_W-1:0] r_hold;
    logic [1:0]          r_anim_frame;

    // Pipeline state
    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_hit_d1;
    logic                r_hit_d2;
    logic [3:0]          r_pal_index;
    logic                r_pix_valid;

    // Stage-1 combinational terms
    logic [10:0]         w_dx;
    logic [10:0]         w_dy;
    logic                w_hit;
    logic [ADDR_W-1:0]   w_col;
    logic [ADDR_W-1:0]   w_addr;

    // Capture the requested sprite state only at the frame boundary.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sx    <= '0;
            r_sy    <= '0;
            r_sen   <= 1'b0;
            r_sflip <= 1'b0;
        end else if (bus.frame_tick) begin
            r_sx    <= bus.duck_x;
            r_sy    <= bus.duck_y;
            r_sen   <= bus.duck_en;
            r_sflip <= bus.flip_h;
        end
    end

    // Advance the animation every FRAME_HOLD unpaused frame ticks.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hold       <= '0;
            r_anim_frame <= '0;
        end else if (bus.frame_tick && !bus.anim_pause) begin
            if (r_hold == c_HOLD_LAST) begin
                r_hold <= '0;
                if (r_anim_frame == c_FRAME_LAST) begin
                    r_anim_frame <= '0;
                end else begin
                    r_anim_frame <= r_anim_frame + 2'd1;
                end
            end else begin
                r_hold <= r_hold + c_HOLD_W'(1);
            end
        end
    end

    // Hit test and ROM address for the pixel presented this cycle. The
    // 11-bit subtraction wraps for pixels left of / above the sprite, which
    // makes them fail the range compare without a separate sign check.
    always_comb begin
        w_dx  = {1'b0, bus.DrawX} - {1'b0, r_sx};
        w_dy  = {1'b0, bus.DrawY} - {1'b0, r_sy};
        w_hit = r_sen && (w_dx < 11'(SPRITE_W)) && (w_dy < 11'(SPRITE_H));
        // Mirrored sprite reads each row right-to-left.
        w_col = r_sflip ? (c_LAST_COL - ADDR_W'(w_dx)) : ADDR_W'(w_dx);
        w_addr = (ADDR_W'(r_anim_frame) * c_FRAME_SIZE)
               + (ADDR_W'(w_dy) * c_SPRITE_W)
               + w_col;
    end

    // Stage 1: register the address (parked at 0 on a miss) and the hit flag,
    // then delay the hit flag one more cycle to meet the ROM read data.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rom_addr <= '0;
            r_hit_d1   <= 1'b0;
            r_hit_d2   <= 1'b0;
        end else begin
            r_rom_addr <= w_hit ? w_addr : '0;
            r_hit_d1   <= w_hit;
            r_hit_d2   <= r_hit_d1;
        end
    end

    // Stage 3: qualify the ROM data; index 0 is transparent background.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pal_index <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_pal_index <= r_hit_d2 ? bus.rom_data : 4'd0;
            r_pix_valid <= r_hit_d2 && (bus.rom_data != 4'd0);
        end
    end

    assign bus.rom_addr   = r_rom_addr;
    assign bus.pal_index  = r_pal_index;
    assign bus.pix_valid  = r_pix_valid;
    assign bus.anim_frame = r_anim_frame;

endmodule
`default_nettype wire

// File: tb/tb_duck_sprite_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_duck_sprite_fetch
//  Brief    : Directed self-checking bench for duck_sprite_fetch. A small
//             synchronous ROM model returns addr[3:0]^3 (or 0 when forced).
//  Revision : 1.0  initial release
// ============================================================================
module tb_duck_sprite_fetch;

    logic clk = 1'b0;
    logic rst;
    logic rom_zero;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    duck_sprite_fetch_if #(.ADDR_W(13)) bus ();

    duck_sprite_fetch #(
        .SPRITE_W  (46),
        .SPRITE_H  (40),
        .NUM_FRAMES(3),
        .FRAME_HOLD(8),
        .ADDR_W    (13)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    function automatic logic [3:0] rom_model(input logic [12:0] a);
        return a[3:0] ^ 4'h3;
    endfunction

    // Synchronous sprite ROM: one cycle read latency.
    always @(posedge clk) bus.rom_data <= rom_zero ? 4'h0 : rom_model(bus.rom_addr);

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 bus.frame_tick = 1'b1;
            @(posedge clk); #1 bus.frame_tick = 1'b0;
        end
    endtask

    // Park on a miss pixel, present (x,y), and sample the address at +1,
    // pix_valid at +2 and the final outputs at +3 cycles.
    task automatic probe(input logic [9:0] x, input logic [9:0] y,
                         output logic [12:0] a, output logic [3:0] p,
                         output logic v, output logic v_early);
        @(posedge clk); #1 bus.DrawX = 10'd0; bus.DrawY = 10'd0;
        repeat (3) @(posedge clk);
        #1 bus.DrawX = x; bus.DrawY = y;
        @(posedge clk); #1 a = bus.rom_addr;
        @(posedge clk); #1 v_early = bus.pix_valid;
        @(posedge clk); #1 p = bus.pal_index; v = bus.pix_valid;
    endtask

    task automatic test_reset();
        int errs;
        errs = 0;
        rst = 1'b1;
        #1;
        total++;
        if (bus.rom_addr !== 13'd0 || bus.pal_index !== 4'd0 || bus.pix_valid !== 1'b0 || bus.anim_frame !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got addr=%0d pal=%0d pv=%0d fr=%0d want all 0",
                     bus.rom_addr, bus.pal_index, bus.pix_valid, bus.anim_frame);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // Live requests without a frame_tick must be ignored.
        bus.duck_x = 10'd0; bus.duck_y = 10'd0; bus.duck_en = 1'b1;
        for (int y = 0; y < 480; y += 8) begin
            for (int x = 0; x < 640; x += 8) begin
                bus.DrawX = 10'(x); bus.DrawY = 10'(y);
                @(posedge clk); #1;
                if (bus.rom_addr !== 13'd0 || bus.pix_valid !== 1'b0 || bus.anim_frame !== 2'd0) errs++;
            end
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL reset_sweep got %0d active samples want 0", errs);
        end
    endtask

    task automatic test_hit();
        logic [12:0] a; logic [3:0] p; logic v, ve;
        bus.duck_x = 10'd100; bus.duck_y = 10'd50; bus.duck_en = 1'b1; bus.flip_h = 1'b0;
        tick(1);
        probe(10'd100, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd0) begin bad++; $display("FAIL hit_origin_addr got=%0d want=0", a); end
        total++; if (ve !== 1'b0) begin bad++; $display("FAIL hit_latency_early got pv=%0d want=0", ve); end
        total++; if (p !== 4'd3 || v !== 1'b1) begin bad++; $display("FAIL hit_origin_pix got pal=%0d pv=%0d want pal=3 pv=1", p, v); end
        probe(10'd145, 10'd89, a, p, v, ve);
        total++; if (a !== 13'd1839) begin bad++; $display("FAIL hit_corner_addr got=%0d want=1839", a); end
        total++; if (p !== 4'hC || v !== 1'b1) begin bad++; $display("FAIL hit_corner_pix got pal=%0d pv=%0d want pal=12 pv=1", p, v); end
        probe(10'd146, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd0 || p !== 4'd0 || v !== 1'b0) begin bad++; $display("FAIL miss_right got addr=%0d pal=%0d pv=%0d want 0", a, p, v); end
        probe(10'd99, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd0 || v !== 1'b0) begin bad++; $display("FAIL miss_left got addr=%0d pv=%0d want 0", a, v); end
        probe(10'd100, 10'd90, a, p, v, ve);
        total++; if (a !== 13'd0 || v !== 1'b0) begin bad++; $display("FAIL miss_below got addr=%0d pv=%0d want 0", a, v); end
    endtask

    task automatic test_flip();
        logic [12:0] a; logic [3:0] p; logic v, ve;
        bus.flip_h = 1'b1;
        tick(1);
        probe(10'd100, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd45) begin bad++; $display("FAIL flip_addr got=%0d want=45", a); end
        total++; if (p !== 4'hE || v !== 1'b1) begin bad++; $display("FAIL flip_pix got pal=%0d pv=%0d want pal=14 pv=1", p, v); end
        probe(10'd145, 10'd51, a, p, v, ve);
        total++; if (a !== 13'd46) begin bad++; $display("FAIL flip_row1_addr got=%0d want=46", a); end
        rom_zero = 1'b1;
        probe(10'd120, 10'd60, a, p, v, ve);
        total++; if (p !== 4'd0 || v !== 1'b0) begin bad++; $display("FAIL transparent got pal=%0d pv=%0d want 0", p, v); end
        rom_zero = 1'b0;
        bus.flip_h = 1'b0;
    endtask

    task automatic test_anim();
        logic [12:0] a; logic [3:0] p; logic v, ve;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        bus.duck_x = 10'd100; bus.duck_y = 10'd50; bus.duck_en = 1'b1;
        bus.flip_h = 1'b0; bus.anim_pause = 1'b0;
        tick(7);
        total++; if (bus.anim_frame !== 2'd0) begin bad++; $display("FAIL anim_7 got=%0d want=0", bus.anim_frame); end
        tick(1);
        total++; if (bus.anim_frame !== 2'd1) begin bad++; $display("FAIL anim_8 got=%0d want=1", bus.anim_frame); end
        probe(10'd100, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd1840) begin bad++; $display("FAIL anim1_addr got=%0d want=1840", a); end
        probe(10'd145, 10'd89, a, p, v, ve);
        total++; if (a !== 13'd3679) begin bad++; $display("FAIL anim1_corner got=%0d want=3679", a); end
        tick(8);
        total++; if (bus.anim_frame !== 2'd2) begin bad++; $display("FAIL anim_16 got=%0d want=2", bus.anim_frame); end
        probe(10'd100, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd3680) begin bad++; $display("FAIL anim2_addr got=%0d want=3680", a); end
        tick(8);
        total++; if (bus.anim_frame !== 2'd0) begin bad++; $display("FAIL anim_wrap got=%0d want=0", bus.anim_frame); end
        bus.anim_pause = 1'b1;
        tick(10);
        total++; if (bus.anim_frame !== 2'd0) begin bad++; $display("FAIL anim_pause got=%0d want=0", bus.anim_frame); end
        bus.anim_pause = 1'b0;
        tick(7);
        total++; if (bus.anim_frame !== 2'd0) begin bad++; $display("FAIL anim_hold_frozen got=%0d want=0", bus.anim_frame); end
        tick(1);
        total++; if (bus.anim_frame !== 2'd1) begin bad++; $display("FAIL anim_resume got=%0d want=1", bus.anim_frame); end
    endtask

    task automatic test_shadow();
        logic [12:0] a; logic [3:0] p; logic v, ve;
        bus.anim_pause = 1'b1;
        bus.duck_x = 10'd200;
        probe(10'd100, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd1840 || v !== 1'b1) begin bad++; $display("FAIL shadow_old_hit got addr=%0d pv=%0d want 1840/1", a, v); end
        probe(10'd200, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd0 || v !== 1'b0) begin bad++; $display("FAIL shadow_new_early got addr=%0d pv=%0d want 0/0", a, v); end
        tick(1);
        probe(10'd200, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd1840 || v !== 1'b1) begin bad++; $display("FAIL shadow_new_hit got addr=%0d pv=%0d want 1840/1", a, v); end
        probe(10'd100, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd0 || v !== 1'b0) begin bad++; $display("FAIL shadow_old_miss got addr=%0d pv=%0d want 0/0", a, v); end
        bus.duck_x = 10'd620;
        tick(1);
        probe(10'd639, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd1859) begin bad++; $display("FAIL clip_last_col got=%0d want=1859", a); end
        total++; if (p !== rom_model(13'd1859) || v !== 1'b0) begin bad++; $display("FAIL clip_last_pix got pal=%0d pv=%0d want pal=0 pv=0", p, v); end
        probe(10'd620, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd1840 || v !== 1'b1) begin bad++; $display("FAIL clip_first got addr=%0d pv=%0d want 1840/1", a, v); end
        probe(10'd0, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd0 || v !== 1'b0) begin bad++; $display("FAIL clip_nowrap got addr=%0d pv=%0d want 0/0", a, v); end
        probe(10'd619, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd0 || v !== 1'b0) begin bad++; $display("FAIL clip_left got addr=%0d pv=%0d want 0/0", a, v); end
    endtask

    task automatic test_reset_mid();
        logic [12:0] a; logic [3:0] p; logic v, ve;
        int waited;
        waited = 0;
        @(posedge clk); #1 bus.DrawX = 10'd620; bus.DrawY = 10'd50;
        while (bus.pix_valid !== 1'b1 && waited < 10) begin
            @(posedge clk); #1 waited++;
        end
        total++; if (bus.pix_valid !== 1'b1 || bus.anim_frame !== 2'd1) begin bad++; $display("FAIL premid_state got pv=%0d fr=%0d want 1/1", bus.pix_valid, bus.anim_frame); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.pix_valid !== 1'b0 || bus.pal_index !== 4'd0 || bus.anim_frame !== 2'd0 || bus.rom_addr !== 13'd0) begin
            bad++;
            $display("FAIL async_reset got pv=%0d pal=%0d fr=%0d addr=%0d want all 0",
                     bus.pix_valid, bus.pal_index, bus.anim_frame, bus.rom_addr);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.anim_pause = 1'b0;
        probe(10'd620, 10'd50, a, p, v, ve);
        total++; if (a !== 13'd0 || v !== 1'b0) begin bad++; $display("FAIL shadow_cleared got addr=%0d pv=%0d want 0/0", a, v); end
        tick(1);
        probe(10'd620, 10'd50, a, p, v, ve);
        total++; if (ve !== 1'b0 || v !== 1'b1 || p !== 4'd3) begin bad++; $display("FAIL recover got early=%0d pv=%0d pal=%0d want 0/1/3", ve, v, p); end
    endtask

    initial begin
        rst = 1'b1; rom_zero = 1'b0;
        bus.DrawX = '0; bus.DrawY = '0; bus.frame_tick = 1'b0;
        bus.duck_x = '0; bus.duck_y = '0; bus.duck_en = 1'b0;
        bus.flip_h = 1'b0; bus.anim_pause = 1'b0;
        test_reset();
        test_hit();
        test_flip();
        test_anim();
        test_shadow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
